// File: rtl/counter_pkg.sv
// Shared types and control decode for the counter bank.
// One op per channel per cycle, picked by fixed priority.
package counter_pkg;

   typedef enum logic [2:0] {
      OP_HOLD,
      OP_CLR,
      OP_LD,
      OP_INC,
      OP_DEC
   } cnt_op_t;

   // clr > ld > (inc xor dec) > hold
   function automatic cnt_op_t decode_op(
      input logic clr,
      input logic ld,
      input logic inc,
      input logic dec
   );
      cnt_op_t op;
      op = OP_HOLD;
      if (clr)
         op = OP_CLR;
      else if (ld)
         op = OP_LD;
      else if (inc && !dec)
         op = OP_INC;
      else if (dec && !inc)
         op = OP_DEC;
      return op;
   endfunction

endpackage

// File: rtl/counter_channel.sv
// One up/down counter with sticky ovf/unf flags
// and a terminal-count level and change pulse.
module counter_channel
   import counter_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             clr,
   input  logic             ld,
   input  logic             inc,
   input  logic             dec,
   input  logic [WIDTH-1:0] ld_val,
   input  logic [WIDTH-1:0] tc_val,
   output logic [WIDTH-1:0] cnt,
   output logic             tc_hit,
   output logic             tc_pulse,
   output logic             ovf,
   output logic             unf
);

   localparam logic [WIDTH:0]   ONE = {{WIDTH{1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

   cnt_op_t          op;
   logic [WIDTH:0]   up;
   logic [WIDTH:0]   dn;
   logic [WIDTH-1:0] cnt_nxt;
   logic             ovf_nxt;
   logic             unf_nxt;
   logic             pulse_nxt;

   // Top bit carries out on MAX+1 and borrows on 0-1.
   assign up = {1'b0, cnt} + ONE;
   assign dn = {1'b0, cnt} - ONE;
   assign op = decode_op(clr, ld, inc, dec);

   always_comb begin
      cnt_nxt = cnt;
      ovf_nxt = ovf;
      unf_nxt = unf;
      unique case (op)
         OP_CLR: begin
            cnt_nxt = '0;
            ovf_nxt = 1'b0;
            unf_nxt = 1'b0;
         end
         OP_LD: begin
            cnt_nxt = ld_val;
            ovf_nxt = 1'b0;
            unf_nxt = 1'b0;
         end
         OP_INC: begin
            cnt_nxt = up[WIDTH-1:0];
            if (up[WIDTH]) begin
               ovf_nxt = 1'b1;
               if (SATURATE)
                  cnt_nxt = MAX;
            end
         end
         OP_DEC: begin
            cnt_nxt = dn[WIDTH-1:0];
            if (dn[WIDTH]) begin
               unf_nxt = 1'b1;
               if (SATURATE)
                  cnt_nxt = '0;
            end
         end
         default: begin
            cnt_nxt = cnt;
         end
      endcase
   end

   // Only a real value change can land on the compare value.
   assign pulse_nxt = (cnt_nxt != cnt) && (cnt_nxt == tc_val);
   assign tc_hit    = (cnt == tc_val);

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cnt      <= '0;
         ovf      <= 1'b0;
         unf      <= 1'b0;
         tc_pulse <= 1'b0;
      end else begin
         cnt      <= cnt_nxt;
         ovf      <= ovf_nxt;
         unf      <= unf_nxt;
         tc_pulse <= pulse_nxt;
      end
   end

endmodule

// File: rtl/counter_bank.sv
// Bank of independent up/down counters on flattened buses.
// Channel i owns bits [i*WIDTH +: WIDTH] of each wide bus.
module counter_bank #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   parameter bit SATURATE = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst_b,
   input  logic [CHANNELS-1:0]       clr_cnt,
   input  logic [CHANNELS-1:0]       ld_cnt,
   input  logic [CHANNELS*WIDTH-1:0] ld_val,
   input  logic [CHANNELS-1:0]       inc_cnt,
   input  logic [CHANNELS-1:0]       dec_cnt,
   input  logic [CHANNELS*WIDTH-1:0] tc_val,
   output logic [CHANNELS*WIDTH-1:0] cnt,
   output logic [CHANNELS-1:0]       tc_hit,
   output logic [CHANNELS-1:0]       tc_pulse,
   output logic [CHANNELS-1:0]       ovf,
   output logic [CHANNELS-1:0]       unf
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      counter_channel #(
         .WIDTH    (WIDTH),
         .SATURATE (SATURATE)
      ) u_ch (
         .clk      (clk),
         .rst_b    (rst_b),
         .clr      (clr_cnt[i]),
         .ld       (ld_cnt[i]),
         .inc      (inc_cnt[i]),
         .dec      (dec_cnt[i]),
         .ld_val   (ld_val[i*WIDTH +: WIDTH]),
         .tc_val   (tc_val[i*WIDTH +: WIDTH]),
         .cnt      (cnt[i*WIDTH +: WIDTH]),
         .tc_hit   (tc_hit[i]),
         .tc_pulse (tc_pulse[i]),
         .ovf      (ovf[i]),
         .unf      (unf[i])
      );
   end

endmodule

// File: tb/tb_counter_bank.sv
// Directed bench for counter_bank: a wrapping and a saturating
// instance share stimulus; expectations queue until the next edge.
module tb_counter_bank;

   localparam int W = 8;
   localparam int N = 4;

   typedef enum int {K_CNT, K_OVF, K_UNF, K_PULSE, K_HIT} kind_t;

   typedef struct {
      string      tag;
      kind_t      k;
      bit         sat;
      int         ch;
      logic [7:0] exp;
   } exp_t;

   logic           clk;
   logic           rst_b;
   logic [N-1:0]   clr_cnt, ld_cnt, inc_cnt, dec_cnt;
   logic [N*W-1:0] ld_val, tc_val;

   logic [N*W-1:0] cnt_w, cnt_s;
   logic [N-1:0]   hit_w, hit_s, pls_w, pls_s;
   logic [N-1:0]   ovf_w, ovf_s, unf_w, unf_s;

   int   checks = 0;
   int   passes = 0;
   exp_t sbq[$];

   counter_bank #(.WIDTH(W), .CHANNELS(N), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .rst_b(rst_b),
      .clr_cnt(clr_cnt), .ld_cnt(ld_cnt), .ld_val(ld_val),
      .inc_cnt(inc_cnt), .dec_cnt(dec_cnt), .tc_val(tc_val),
      .cnt(cnt_w), .tc_hit(hit_w), .tc_pulse(pls_w),
      .ovf(ovf_w), .unf(unf_w)
   );

   counter_bank #(.WIDTH(W), .CHANNELS(N), .SATURATE(1'b1)) u_sat (
      .clk(clk), .rst_b(rst_b),
      .clr_cnt(clr_cnt), .ld_cnt(ld_cnt), .ld_val(ld_val),
      .inc_cnt(inc_cnt), .dec_cnt(dec_cnt), .tc_val(tc_val),
      .cnt(cnt_s), .tc_hit(hit_s), .tc_pulse(pls_s),
      .ovf(ovf_s), .unf(unf_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] obs(kind_t k, bit sat, int ch);
      logic [7:0] v;
      v = '0;
      case (k)
         K_CNT:   v = sat ? cnt_s[ch*W +: W] : cnt_w[ch*W +: W];
         K_OVF:   v = {7'b0, sat ? ovf_s[ch] : ovf_w[ch]};
         K_UNF:   v = {7'b0, sat ? unf_s[ch] : unf_w[ch]};
         K_PULSE: v = {7'b0, sat ? pls_s[ch] : pls_w[ch]};
         K_HIT:   v = {7'b0, sat ? hit_s[ch] : hit_w[ch]};
         default: v = 'x;
      endcase
      return v;
   endfunction

   task automatic check(string tag, logic [31:0] o, logic [31:0] e);
      checks++;
      assert (o === e) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
   endtask

   task automatic exp_push(string tag, kind_t k, bit sat, int ch,
                           logic [7:0] e);
      exp_t x;
      x.tag = tag;
      x.k   = k;
      x.sat = sat;
      x.ch  = ch;
      x.exp = e;
      sbq.push_back(x);
   endtask

   task automatic tick();
      exp_t x;
      @(posedge clk);
      #1;
      while (sbq.size() > 0) begin
         x = sbq.pop_front();
         check(x.tag, {24'b0, obs(x.k, x.sat, x.ch)}, {24'b0, x.exp});
      end
   endtask

   task automatic idle();
      clr_cnt = '0;
      ld_cnt  = '0;
      inc_cnt = '0;
      dec_cnt = '0;
   endtask

   initial begin
      rst_b  = 1'b0;
      idle();
      ld_val = '0;
      tc_val = {4{8'hC3}};
      tc_val[3*W +: W] = 8'h00;
      repeat (2) @(posedge clk);
      #1 rst_b = 1'b1;

      // preload ch0=0x37 and push ch1 over the top
      ld_cnt = 4'b0011;
      ld_val[0*W +: W] = 8'h37;
      ld_val[1*W +: W] = 8'hFF;
      exp_push("pre_ld_c0", K_CNT, 0, 0, 8'h37);
      exp_push("pre_ld_c1", K_CNT, 0, 1, 8'hFF);
      tick();
      idle();
      inc_cnt = 4'b0011;
      exp_push("pre_inc_c0", K_CNT, 0, 0, 8'h38);
      exp_push("pre_wrap_ovf", K_OVF, 0, 1, 1);
      exp_push("pre_sat_cnt", K_CNT, 1, 1, 8'hFF);
      exp_push("pre_sat_ovf", K_OVF, 1, 1, 1);
      tick();

      // async reset mid-count, inputs still active
      rst_b = 1'b0;
      #1;
      check("rst_cnt_w", cnt_w, 0);
      check("rst_cnt_s", cnt_s, 0);
      check("rst_ovf", {ovf_s, ovf_w}, 0);
      check("rst_unf", {unf_s, unf_w}, 0);
      check("rst_pulse", {pls_s, pls_w}, 0);
      check("rst_hit", hit_w, 4'b1000);
      idle();
      @(negedge clk);
      rst_b = 1'b1;
      tc_val[3*W +: W] = 8'hC3;

      // wrap on ch1
      ld_cnt[1] = 1'b1;
      ld_val[1*W +: W] = 8'hFE;
      exp_push("wrap_ld", K_CNT, 0, 1, 8'hFE);
      tick();
      idle();
      inc_cnt[1] = 1'b1;
      exp_push("wrap_ff", K_CNT, 0, 1, 8'hFF);
      exp_push("wrap_ff_ovf", K_OVF, 0, 1, 0);
      tick();
      exp_push("wrap_00", K_CNT, 0, 1, 8'h00);
      exp_push("wrap_00_ovf", K_OVF, 0, 1, 1);
      tick();
      exp_push("wrap_01", K_CNT, 0, 1, 8'h01);
      exp_push("wrap_01_ovf", K_OVF, 0, 1, 1);
      tick();
      idle();
      ld_cnt[1] = 1'b1;
      ld_val[1*W +: W] = 8'h20;
      exp_push("wrap_ld_clr", K_OVF, 0, 1, 0);
      exp_push("wrap_ld_val", K_CNT, 0, 1, 8'h20);
      tick();

      // saturate low on ch2 with tc=0
      idle();
      tc_val[2*W +: W] = 8'h00;
      ld_cnt[2] = 1'b1;
      ld_val[2*W +: W] = 8'h01;
      exp_push("sat_ld", K_CNT, 1, 2, 8'h01);
      tick();
      idle();
      dec_cnt[2] = 1'b1;
      exp_push("sat_d1", K_CNT, 1, 2, 8'h00);
      exp_push("sat_d1_unf", K_UNF, 1, 2, 0);
      exp_push("sat_d1_pls", K_PULSE, 1, 2, 1);
      tick();
      exp_push("sat_d2", K_CNT, 1, 2, 8'h00);
      exp_push("sat_d2_unf", K_UNF, 1, 2, 1);
      exp_push("sat_d2_pls", K_PULSE, 1, 2, 0);
      exp_push("wrp_d2", K_CNT, 0, 2, 8'hFF);
      exp_push("wrp_d2_unf", K_UNF, 0, 2, 1);
      tick();
      exp_push("sat_d3", K_CNT, 1, 2, 8'h00);
      exp_push("sat_d3_unf", K_UNF, 1, 2, 1);
      exp_push("sat_d3_pls", K_PULSE, 1, 2, 0);
      tick();
      idle();
      tc_val[2*W +: W] = 8'hC3;

      // priority on ch3
      ld_cnt[3] = 1'b1;
      ld_val[3*W +: W] = 8'h10;
      exp_push("pri_pre", K_CNT, 0, 3, 8'h10);
      tick();
      clr_cnt[3] = 1'b1;
      inc_cnt[3] = 1'b1;
      ld_val[3*W +: W] = 8'hAA;
      exp_push("pri_clr", K_CNT, 0, 3, 8'h00);
      tick();
      clr_cnt[3] = 1'b0;
      exp_push("pri_ld", K_CNT, 0, 3, 8'hAA);
      tick();
      ld_cnt[3] = 1'b0;
      dec_cnt[3] = 1'b1;
      exp_push("pri_hold", K_CNT, 0, 3, 8'hAA);
      exp_push("pri_hold_ovf", K_OVF, 0, 3, 0);
      tick();
      idle();

      // independence
      ld_cnt = 4'hF;
      ld_val = {4{8'h10}};
      for (int i = 0; i < N; i++)
         exp_push("ind_pre", K_CNT, 0, i, 8'h10);
      tick();
      idle();
      inc_cnt[0] = 1'b1;
      dec_cnt[1] = 1'b1;
      ld_cnt[2]  = 1'b1;
      ld_val[2*W +: W] = 8'h55;
      clr_cnt[3] = 1'b1;
      exp_push("ind_c0", K_CNT, 0, 0, 8'h11);
      exp_push("ind_c1", K_CNT, 0, 1, 8'h0F);
      exp_push("ind_c2", K_CNT, 0, 2, 8'h55);
      exp_push("ind_c3", K_CNT, 0, 3, 8'h00);
      tick();
      idle();

      // terminal count on ch0
      tc_val[0*W +: W] = 8'h05;
      clr_cnt[0] = 1'b1;
      exp_push("tc_clr", K_CNT, 0, 0, 8'h00);
      exp_push("tc_clr_pls", K_PULSE, 0, 0, 0);
      tick();
      idle();
      inc_cnt[0] = 1'b1;
      for (int v = 1; v <= 6; v++) begin
         exp_push("tc_cnt", K_CNT, 0, 0, 8'(v));
         exp_push("tc_pls", K_PULSE, 0, 0, (v == 5) ? 8'd1 : 8'd0);
         exp_push("tc_hit", K_HIT, 0, 0, (v == 5) ? 8'd1 : 8'd0);
         tick();
      end
      idle();
      tc_val[0*W +: W] = 8'h07;
      exp_push("tcv7_pls", K_PULSE, 0, 0, 0);
      exp_push("tcv7_hit", K_HIT, 0, 0, 0);
      tick();
      tc_val[0*W +: W] = 8'h06;
      exp_push("tcv6_pls", K_PULSE, 0, 0, 0);
      exp_push("tcv6_hit", K_HIT, 0, 0, 1);
      tick();
      ld_cnt[0] = 1'b1;
      ld_val[0*W +: W] = 8'h06;
      exp_push("tc_same_ld", K_PULSE, 0, 0, 0);
      tick();
      idle();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
